// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// length-field and word sizes of the incoming program stream.
package loader_pkg;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int WORD_BITS  = WORD_BYTES * 8;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted stream bytes into big-endian 32-bit words. The first three
// bytes of a word sit in a shift register; the fourth arrives combinationally
// so the complete word is available in the same cycle it is accepted.
module word_assembler
    import loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 byte_en,
    input  logic [7:0]           byte_in,
    output logic                 word_done,
    output logic [WORD_BITS-1:0] word
);

    logic [WORD_BITS-9:0] shift;
    logic [1:0]           count;

    assign word      = {shift, byte_in};
    assign word_done = byte_en && (count == 2'(WORD_BYTES - 1));

    // Shift in each accepted byte; the byte counter wraps after the last byte of a word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift <= '0;
            count <= '0;
        end else if (clear) begin
            shift <= '0;
            count <= '0;
        end else if (byte_en) begin
            shift <= word[WORD_BITS-9:0];
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed byte stream, writes the payload
// words into program memory, and releases the processor reset once the load
// completes. Defining LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// that must match the payload for the load to be accepted.
//
// Handshake: a byte is consumed on a rising edge where in_Valid and out_Ready
// are both 1. out_Ready is registered and does not depend on in_Valid; the
// source may hold or change in_Byte freely while in_Valid is 0.
module program_loader
    import loader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 512,
    parameter int NBits        = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      in_Byte,
    input  logic                            in_Valid,
    output logic                            out_Ready,
    input  logic                            in_Restart,
    output logic                            out_WrEn,
    output logic [$clog2(MEMORY_DEPTH)-1:0] out_WrAddr,
    output logic [NBits-1:0]                out_WrData,
    output logic                            out_CpuReset,
    output logic                            out_Done,
    output logic                            out_Error,
    output logic [2:0]                      dbg_state
);

    localparam int AW = $clog2(MEMORY_DEPTH);

    state_t                   state;
    logic [8*(LEN_BYTES-1)-1:0] len_hi;
    logic [15:0]              len;
    logic [15:0]              len_next;
    logic [15:0]              word_count;
    logic                     accept;
    logic                     asm_en;
    logic                     asm_clear;
    logic                     word_done;
    logic [WORD_BITS-1:0]     asm_word;

    assign accept    = in_Valid && out_Ready;
    assign asm_en    = accept && (state == DATA);
    // Restart only takes effect from a terminal state; elsewhere it is ignored.
    assign asm_clear = in_Restart && ((state == DONE) || (state == ERROR));
    assign len_next  = {len_hi, in_Byte};
    assign dbg_state = state;

    word_assembler u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .byte_en   (asm_en),
        .byte_in   (in_Byte),
        .word_done (word_done),
        .word      (asm_word)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of all payload bytes, compared against the trailing byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= '0;
        end else if (asm_clear) begin
            csum <= '0;
        end else if (asm_en) begin
            csum <= csum ^ in_Byte;
        end
    end
`endif

    // Load sequencer with registered handshake, write-port and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= LEN_HI;
            len_hi       <= '0;
            len          <= '0;
            word_count   <= '0;
            out_Ready    <= 1'b0;
            out_WrEn     <= 1'b0;
            out_WrAddr   <= '0;
            out_WrData   <= '0;
            out_CpuReset <= 1'b0;
            out_Done     <= 1'b0;
            out_Error    <= 1'b0;
        end else begin
            out_WrEn <= 1'b0;
            case (state)
                LEN_HI: begin
                    out_Ready <= 1'b1;
                    if (accept) begin
                        len_hi <= in_Byte;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len <= len_next;
                        if (len_next == 16'd0) begin
                            state <= CHECK;
                        end else if (32'(len_next) > MEMORY_DEPTH) begin
                            state     <= ERROR;
                            out_Ready <= 1'b0;
                            out_Error <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    // The strobe is raised on the cycle after the word's last byte.
                    if (word_done) begin
                        out_WrEn   <= 1'b1;
                        out_WrAddr <= word_count[AW-1:0];
                        out_WrData <= NBits'(asm_word);
                        word_count <= word_count + 16'd1;
                        if (word_count == len - 16'd1) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                    if (accept) begin
                        out_Ready <= 1'b0;
                        if (in_Byte == csum) begin
                            state        <= DONE;
                            out_Done     <= 1'b1;
                            out_CpuReset <= 1'b1;
                        end else begin
                            state     <= ERROR;
                            out_Error <= 1'b1;
                        end
                    end
`else
                    state        <= DONE;
                    out_Ready    <= 1'b0;
                    out_Done     <= 1'b1;
                    out_CpuReset <= 1'b1;
`endif
                end
                DONE: begin
                    if (in_Restart) begin
                        state        <= LEN_HI;
                        word_count   <= '0;
                        out_Done     <= 1'b0;
                        out_CpuReset <= 1'b0;
                        out_Ready    <= 1'b1;
                    end
                end
                ERROR: begin
                    if (in_Restart) begin
                        state      <= LEN_HI;
                        word_count <= '0;
                        out_Error  <= 1'b0;
                        out_Ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= LEN_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader (MEMORY_DEPTH=512, NBits=32).
// Builds with or without LOADER_CHECKSUM_EN; the stream driver appends the
// trailing checksum byte only when the macro is defined.
module tb_program_loader;
    import loader_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  in_Byte;
    logic        in_Valid;
    logic        out_Ready;
    logic        in_Restart;
    logic        out_WrEn;
    logic [8:0]  out_WrAddr;
    logic [31:0] out_WrData;
    logic        out_CpuReset;
    logic        out_Done;
    logic        out_Error;
    logic [2:0]  dbg_state;

    int vec_count  = 0;
    int fail_count = 0;

    logic [31:0] exp_q[$];
    logic [8:0]  cap_addr_q[$];
    logic [31:0] cap_data_q[$];

    program_loader #(.MEMORY_DEPTH(512), .NBits(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_Byte      (in_Byte),
        .in_Valid     (in_Valid),
        .out_Ready    (out_Ready),
        .in_Restart   (in_Restart),
        .out_WrEn     (out_WrEn),
        .out_WrAddr   (out_WrAddr),
        .out_WrData   (out_WrData),
        .out_CpuReset (out_CpuReset),
        .out_Done     (out_Done),
        .out_Error    (out_Error),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write-port monitor
    always @(negedge clk) begin
        if (reset && out_WrEn) begin
            cap_addr_q.push_back(out_WrAddr);
            cap_data_q.push_back(out_WrData);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        @(negedge clk);
        if (gaps) begin
            guard = 0;
            while ($urandom_range(0, 1) == 0 && guard < 4) begin
                in_Byte = 8'($urandom);
                @(negedge clk);
                guard++;
            end
        end
        in_Byte  = b;
        in_Valid = 1'b1;
        guard    = 0;
        while (!out_Ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!out_Ready) begin
            vec_count++;
            fail_count++;
            $display("FAIL send_byte: out_Ready=%b after %0d cycles, required 1", out_Ready, guard);
        end
        @(posedge clk);
        #1;
        in_Valid = 1'b0;
        in_Byte  = 8'h00;
    endtask

    task automatic send_payload(input bit gaps);
        logic [15:0] n;
        logic [31:0] w;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0]  cs;
        cs = 8'h00;
`endif
        n = 16'(exp_q.size());
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
        foreach (exp_q[i]) begin
            w = exp_q[i];
            for (int k = 3; k >= 0; k--) begin
                send_byte(w[k*8 +: 8], gaps);
`ifdef LOADER_CHECKSUM_EN
                cs = cs ^ w[k*8 +: 8];
`endif
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs, gaps);
`endif
    endtask

    task automatic wait_end(input string name);
        int guard;
        guard = 0;
        while (!(out_Done || out_Error) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        vec_count++;
        if (!(out_Done || out_Error)) begin
            fail_count++;
            $display("FAIL %s end: no Done/Error after %0d cycles, required one of them", name, guard);
        end
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        in_Restart = 1'b1;
        @(negedge clk);
        in_Restart = 1'b0;
    endtask

    task automatic clear_queues();
        exp_q.delete();
        cap_addr_q.delete();
        cap_data_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; in_Byte = 8'h00; in_Valid = 1'b0; in_Restart = 1'b0;
        repeat (3) @(negedge clk);
        vec_count++; if (out_Ready !== 1'b0) begin fail_count++; $display("FAIL reset ready: got %b want 0", out_Ready); end
        vec_count++; if (out_WrEn !== 1'b0) begin fail_count++; $display("FAIL reset wren: got %b want 0", out_WrEn); end
        vec_count++; if (out_WrAddr !== 9'd0) begin fail_count++; $display("FAIL reset wraddr: got %h want 0", out_WrAddr); end
        vec_count++; if (out_WrData !== 32'd0) begin fail_count++; $display("FAIL reset wrdata: got %h want 0", out_WrData); end
        vec_count++; if (out_CpuReset !== 1'b0) begin fail_count++; $display("FAIL reset cpureset: got %b want 0", out_CpuReset); end
        vec_count++; if (out_Done !== 1'b0) begin fail_count++; $display("FAIL reset done: got %b want 0", out_Done); end
        vec_count++; if (out_Error !== 1'b0) begin fail_count++; $display("FAIL reset error: got %b want 0", out_Error); end
        vec_count++; if (dbg_state !== 3'(LEN_HI)) begin fail_count++; $display("FAIL reset state: got %0d want %0d", dbg_state, LEN_HI); end
        reset = 1'b1;
        @(negedge clk);
        vec_count++; if (out_Ready !== 1'b1) begin fail_count++; $display("FAIL reset release ready: got %b want 1", out_Ready); end
    endtask

    task automatic test_two_words();
        clear_queues();
        exp_q.push_back(32'h11223344);
        exp_q.push_back(32'hAABBCCDD);
        send_payload(1'b0);
`ifndef LOADER_CHECKSUM_EN
        @(negedge clk);
        vec_count++; if (dbg_state !== 3'(CHECK)) begin fail_count++; $display("FAIL two_words check state: got %0d want %0d", dbg_state, CHECK); end
`endif
        wait_end("two_words");
        vec_count++; if (cap_addr_q.size() != 2) begin fail_count++; $display("FAIL two_words count: got %0d want 2", cap_addr_q.size()); end
        for (int i = 0; i < cap_addr_q.size() && i < 2; i++) begin
            vec_count++; if (cap_addr_q[i] !== 9'(i)) begin fail_count++; $display("FAIL two_words addr%0d: got %0d want %0d", i, cap_addr_q[i], i); end
            vec_count++; if (cap_data_q[i] !== exp_q[i]) begin fail_count++; $display("FAIL two_words data%0d: got %h want %h", i, cap_data_q[i], exp_q[i]); end
        end
        vec_count++; if (out_Done !== 1'b1) begin fail_count++; $display("FAIL two_words done: got %b want 1", out_Done); end
        vec_count++; if (out_CpuReset !== 1'b1) begin fail_count++; $display("FAIL two_words cpureset: got %b want 1", out_CpuReset); end
        vec_count++; if (out_Ready !== 1'b0) begin fail_count++; $display("FAIL two_words ready in done: got %b want 0", out_Ready); end
        vec_count++; if (out_Error !== 1'b0) begin fail_count++; $display("FAIL two_words error: got %b want 0", out_Error); end
        pulse_restart();
        vec_count++; if (dbg_state !== 3'(LEN_HI)) begin fail_count++; $display("FAIL restart state: got %0d want %0d", dbg_state, LEN_HI); end
        vec_count++; if (out_Done !== 1'b0) begin fail_count++; $display("FAIL restart done: got %b want 0", out_Done); end
        vec_count++; if (out_CpuReset !== 1'b0) begin fail_count++; $display("FAIL restart cpureset: got %b want 0", out_CpuReset); end
        vec_count++; if (out_Ready !== 1'b1) begin fail_count++; $display("FAIL restart ready: got %b want 1", out_Ready); end
    endtask

    task automatic test_oversize();
        clear_queues();
        send_byte(8'h02, 1'b0);
        send_byte(8'h01, 1'b0);
        wait_end("oversize");
        vec_count++; if (out_Error !== 1'b1) begin fail_count++; $display("FAIL oversize error: got %b want 1", out_Error); end
        vec_count++; if (out_Done !== 1'b0) begin fail_count++; $display("FAIL oversize done: got %b want 0", out_Done); end
        vec_count++; if (out_Ready !== 1'b0) begin fail_count++; $display("FAIL oversize ready: got %b want 0", out_Ready); end
        repeat (5) @(negedge clk);
        vec_count++; if (out_Error !== 1'b1) begin fail_count++; $display("FAIL oversize error held: got %b want 1", out_Error); end
        vec_count++; if (out_CpuReset !== 1'b0) begin fail_count++; $display("FAIL oversize cpureset: got %b want 0", out_CpuReset); end
        vec_count++; if (cap_addr_q.size() != 0) begin fail_count++; $display("FAIL oversize writes: got %0d want 0", cap_addr_q.size()); end
        pulse_restart();
        vec_count++; if (out_Error !== 1'b0) begin fail_count++; $display("FAIL oversize restart error: got %b want 0", out_Error); end
        vec_count++; if (out_Ready !== 1'b1) begin fail_count++; $display("FAIL oversize restart ready: got %b want 1", out_Ready); end
        vec_count++; if (out_CpuReset !== 1'b0) begin fail_count++; $display("FAIL oversize restart cpureset: got %b want 0", out_CpuReset); end
    endtask

    task automatic test_random_valid();
        clear_queues();
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h01234567);
        exp_q.push_back(32'h89ABCDEF);
        exp_q.push_back(32'hCAFEF00D);
        send_payload(1'b1);
        wait_end("random_valid");
        vec_count++; if (cap_addr_q.size() != 4) begin fail_count++; $display("FAIL random_valid count: got %0d want 4", cap_addr_q.size()); end
        for (int i = 0; i < cap_addr_q.size() && i < 4; i++) begin
            vec_count++; if (cap_addr_q[i] !== 9'(i)) begin fail_count++; $display("FAIL random_valid addr%0d: got %0d want %0d", i, cap_addr_q[i], i); end
            vec_count++; if (cap_data_q[i] !== exp_q[i]) begin fail_count++; $display("FAIL random_valid data%0d: got %h want %h", i, cap_data_q[i], exp_q[i]); end
        end
        vec_count++; if (out_Done !== 1'b1) begin fail_count++; $display("FAIL random_valid done: got %b want 1", out_Done); end
        pulse_restart();
    endtask

    task automatic test_reset_mid_load();
        clear_queues();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i), 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        vec_count++; if (out_WrEn !== 1'b0) begin fail_count++; $display("FAIL midreset wren: got %b want 0", out_WrEn); end
        vec_count++; if (out_WrAddr !== 9'd0) begin fail_count++; $display("FAIL midreset wraddr: got %h want 0", out_WrAddr); end
        vec_count++; if (out_WrData !== 32'd0) begin fail_count++; $display("FAIL midreset wrdata: got %h want 0", out_WrData); end
        vec_count++; if (out_Ready !== 1'b0) begin fail_count++; $display("FAIL midreset ready: got %b want 0", out_Ready); end
        vec_count++; if (dbg_state !== 3'(LEN_HI)) begin fail_count++; $display("FAIL midreset state: got %0d want %0d", dbg_state, LEN_HI); end
        repeat (2) @(negedge clk);
        cap_addr_q.delete();
        cap_data_q.delete();
        reset = 1'b1;
        exp_q.push_back(32'h5A6B7C8D);
        send_payload(1'b0);
        wait_end("midreset");
        vec_count++; if (cap_addr_q.size() != 1) begin fail_count++; $display("FAIL midreset count: got %0d want 1", cap_addr_q.size()); end
        if (cap_addr_q.size() > 0) begin
            vec_count++; if (cap_addr_q[0] !== 9'd0) begin fail_count++; $display("FAIL midreset addr: got %0d want 0", cap_addr_q[0]); end
            vec_count++; if (cap_data_q[0] !== 32'h5A6B7C8D) begin fail_count++; $display("FAIL midreset data: got %h want 5a6b7c8d", cap_data_q[0]); end
        end
        vec_count++; if (out_Done !== 1'b1) begin fail_count++; $display("FAIL midreset done: got %b want 1", out_Done); end
        pulse_restart();
    endtask

    task automatic test_restart_ignored();
        clear_queues();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        pulse_restart();
        vec_count++; if (dbg_state !== 3'(DATA)) begin fail_count++; $display("FAIL ignore_restart state: got %0d want %0d", dbg_state, DATA); end
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h08, 1'b0);
`endif
        wait_end("ignore_restart");
        vec_count++; if (cap_addr_q.size() != 1) begin fail_count++; $display("FAIL ignore_restart count: got %0d want 1", cap_addr_q.size()); end
        if (cap_data_q.size() > 0) begin
            vec_count++; if (cap_data_q[0] !== 32'h12345678) begin fail_count++; $display("FAIL ignore_restart data: got %h want 12345678", cap_data_q[0]); end
        end
        vec_count++; if (out_Done !== 1'b1) begin fail_count++; $display("FAIL ignore_restart done: got %b want 1", out_Done); end
        pulse_restart();
    endtask

    task automatic test_zero_len();
        clear_queues();
        send_payload(1'b0);
        wait_end("zero_len");
        vec_count++; if (out_Done !== 1'b1) begin fail_count++; $display("FAIL zero_len done: got %b want 1", out_Done); end
        vec_count++; if (out_CpuReset !== 1'b1) begin fail_count++; $display("FAIL zero_len cpureset: got %b want 1", out_CpuReset); end
        vec_count++; if (cap_addr_q.size() != 0) begin fail_count++; $display("FAIL zero_len writes: got %0d want 0", cap_addr_q.size()); end
        pulse_restart();
    endtask

    task automatic test_full_depth();
        logic [15:0] idx;
        clear_queues();
        for (int i = 0; i < 512; i++) begin
            idx = 16'(i);
            exp_q.push_back({idx ^ 16'hA5C3, ~idx});
        end
        send_payload(1'b0);
        wait_end("full_depth");
        vec_count++; if (cap_addr_q.size() != 512) begin fail_count++; $display("FAIL full_depth count: got %0d want 512", cap_addr_q.size()); end
        for (int i = 0; i < cap_addr_q.size() && i < 512; i++) begin
            vec_count++; if (cap_addr_q[i] !== 9'(i) || cap_data_q[i] !== exp_q[i]) begin
                fail_count++;
                $display("FAIL full_depth word%0d: got %0d/%h want %0d/%h", i, cap_addr_q[i], cap_data_q[i], i, exp_q[i]);
            end
        end
        vec_count++; if (out_Done !== 1'b1) begin fail_count++; $display("FAIL full_depth done: got %b want 1", out_Done); end
        pulse_restart();
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] good_stream [7];
        good_stream = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        clear_queues();
        foreach (good_stream[i]) send_byte(good_stream[i], 1'b0);
        wait_end("csum_good");
        vec_count++; if (out_Done !== 1'b1) begin fail_count++; $display("FAIL csum_good done: got %b want 1", out_Done); end
        vec_count++; if (out_Error !== 1'b0) begin fail_count++; $display("FAIL csum_good error: got %b want 0", out_Error); end
        pulse_restart();
        clear_queues();
        good_stream[6] = 8'h05;
        foreach (good_stream[i]) send_byte(good_stream[i], 1'b0);
        wait_end("csum_bad");
        vec_count++; if (out_Error !== 1'b1) begin fail_count++; $display("FAIL csum_bad error: got %b want 1", out_Error); end
        vec_count++; if (out_CpuReset !== 1'b0) begin fail_count++; $display("FAIL csum_bad cpureset: got %b want 0", out_CpuReset); end
        vec_count++; if (cap_data_q.size() != 1) begin fail_count++; $display("FAIL csum_bad writes: got %0d want 1", cap_data_q.size()); end
        if (cap_data_q.size() > 0) begin
            vec_count++; if (cap_data_q[0] !== 32'h01020304) begin fail_count++; $display("FAIL csum_bad data: got %h want 01020304", cap_data_q[0]); end
        end
        pulse_restart();
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_two_words();
        test_oversize();
        test_random_valid();
        test_reset_mid_load();
        test_restart_ignored();
        test_zero_len();
        test_full_depth();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter MEMORY_DEPTH, default 512, meaning the number of 32-bit words in program memory.
REQ-002 The block SHALL have parameter NBits, default 32, meaning the write data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_Byte, input, 8 bits: the incoming program stream byte.
REQ-006 The block SHALL have port in_Valid, input, 1 bit: in_Byte is valid.
REQ-007 The block SHALL have port out_Ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-008 The block SHALL have port in_Restart, input, 1 bit: a one-cycle pulse that starts a new load.
REQ-009 The block SHALL have port out_WrEn, output, 1 bit: the program-memory write strobe.
REQ-010 The block SHALL have port out_WrAddr, output, clog2(MEMORY_DEPTH) bits: the word address.
REQ-011 The block SHALL have port out_WrData, output, NBits bits: the assembled word.
REQ-012 The block SHALL have port out_CpuReset, output, 1 bit: the active-low reset to the processor; 0 holds the processor.
REQ-013 The block SHALL have port out_Done, output, 1 bit: the load completed successfully.
REQ-014 The block SHALL have port out_Error, output, 1 bit: the load was rejected.

Function
REQ-015 A byte SHALL be accepted only in a cycle where in_Valid=1 and out_Ready=1.
REQ-016 Stream format SHALL be a 16-bit word count N, sent big-endian, followed by 4N payload bytes forming big-endian words.
REQ-017 The FSM SHALL have states LEN_HI, LEN_LO, DATA, CHECK, DONE and ERROR.
REQ-018 out_Ready SHALL be 1 in LEN_HI, LEN_LO, DATA and CHECK, and 0 in DONE and ERROR.
REQ-019 State transitions SHALL be:
  - LEN_HI->LEN_LO on an accepted byte.
  - LEN_LO->DATA on an accepted byte when 0<N<=MEMORY_DEPTH.
  - LEN_LO->ERROR when N>MEMORY_DEPTH.
  - LEN_LO->CHECK when N==0.
REQ-020 In DATA, the 4th accepted byte of each word SHALL cause out_WrEn=1 for exactly one cycle, on the following cycle.
REQ-021 During that strobe, out_WrData SHALL hold the assembled word and out_WrAddr SHALL hold the word index, starting at 0 and incrementing by 1.
REQ-022 After the write of word N-1, the FSM SHALL move DATA->CHECK; the address SHALL never wrap.
REQ-023 CHECK SHALL pass straight to DONE when the checksum feature is absent (see Configuration).
REQ-024 In DONE: out_Done=1 and out_CpuReset=1. In every other state: out_CpuReset=0.
REQ-025 In ERROR: out_Error=1, out_CpuReset=0, and the FSM SHALL remain there until in_Restart.
REQ-026 in_Restart SHALL act only in DONE or ERROR: it clears the word counter, out_Done and out_Error, and enters LEN_HI. It SHALL be ignored in all other states.
REQ-027 When a write strobe and an accepted byte occur in the same cycle, both SHALL be honoured with no byte lost.

Reset
REQ-028 Asserting reset (0) at any time, including mid-load, SHALL immediately force the following, with no partial word written afterwards:
  - state LEN_HI
  - out_WrEn=0, out_WrAddr=0, out_WrData=0
  - out_CpuReset=0, out_Done=0, out_Error=0
  - out_Ready=0 while reset is held, then 1 from the first clock after release

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN defined: CHECK SHALL accept one trailing byte and compare it with the XOR of all payload bytes (0x00 when N=0). On a match it SHALL go to DONE; on a mismatch it SHALL go to ERROR, and words already written remain in memory.
REQ-030 Macro LOADER_CHECKSUM_EN undefined: no trailing byte SHALL be consumed, CHECK SHALL last one cycle, and there SHALL be no checksum logic.

Structure
REQ-031 Shared package loader_pkg SHALL hold the state enum typedef and the LEN_BYTES=2 and WORD_BYTES=4 constants.
REQ-032 Byte-to-word packing (shift register plus 2-bit byte counter) SHALL live in one sub-module, word_assembler, instantiated once.

Verification
REQ-033 Stream 00 02 11 22 33 44 AA BB CC DD -> writes addr0=0x11223344 and addr1=0xAABBCCDD, then out_Done=1 and out_CpuReset=1.
REQ-034 Count 0x0201 with MEMORY_DEPTH=512 -> ERROR, out_Error=1, no writes, out_CpuReset=0 until in_Restart.
REQ-035 in_Valid toggled randomly at 50% during a 4-word load -> exactly 4 strobes, addresses 0..3, data intact.
REQ-036 reset pulsed after 6 payload bytes, then a full reload of 1 word -> single write to addr0, no stale bytes.
REQ-037 LOADER_CHECKSUM_EN with stream 00 01 01 02 03 04 then 0x04 -> DONE; with 0x05 -> ERROR, word still written.
REQ-038 in_Restart pulsed during DATA -> ignored; in DONE -> LEN_HI, out_CpuReset=0, out_Done=0.
